// File: rtl/core_scheduler.sv
// core_scheduler: per-core control FSM. It walks one instruction at a time
// through FETCH, DECODE, REQUEST, WAIT, EXECUTE and WRITEBACK. It also holds
// the converged program counter, latches normal completion (RET) and aborts
// with an error flag if the memory wait stalls for too long.
//
// Fetch handshake: fetch_req is high for every cycle the core is in FETCH.
// The fetcher raises fetch_done once the instruction for current_pc is
// latched. FETCH is left on the first clock edge that samples fetch_req and
// fetch_done both high. There is no timeout on that wait.
module core_scheduler #(
    parameter int THREADS      = 4,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         thread_count,
    input  logic               fetch_done,
    input  logic               decoded_ret,
    input  logic [THREADS-1:0] lsu_busy,
    input  logic [7:0]         next_pc,
    output logic [2:0]         core_state,
    output logic               fetch_req,
    output logic [7:0]         current_pc,
    output logic               done,
    output logic               error
);

    localparam logic [2:0] CORE_IDLE      = 3'd0;
    localparam logic [2:0] CORE_FETCH     = 3'd1;
    localparam logic [2:0] CORE_DECODE    = 3'd2;
    localparam logic [2:0] CORE_REQUEST   = 3'd3;
    localparam logic [2:0] CORE_WAIT      = 3'd4;
    localparam logic [2:0] CORE_EXECUTE   = 3'd5;
    localparam logic [2:0] CORE_WRITEBACK = 3'd6;
    localparam logic [2:0] CORE_DONE      = 3'd7;

    // Last counter value allowed in WAIT. The counter starts at 0 on WAIT
    // entry, so WAIT lasts at most WAIT_TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [7:0]         r_pc;
    logic [7:0]         r_wait_cnt;
    logic               r_done;
    logic               r_error;
    logic [THREADS-1:0] w_mask;
    logic               w_lanes_idle;
    logic               w_wait_expired;

    // Active-lane mask: lane i takes part iff i < thread_count. Counts above
    // THREADS therefore saturate to all lanes, and a count of 0 gives no lanes.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < THREADS; i++) begin
            w_mask[i] = ({29'd0, thread_count} > 32'(i));
        end
    end

    assign w_lanes_idle   = ((lsu_busy & w_mask) == '0);
    assign w_wait_expired = (r_wait_cnt == WAIT_LAST);

    // State register: one registered transition per clock. Reset drops any
    // instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CORE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. In WAIT, the lanes-idle exit wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CORE_IDLE:      if (start) w_next_state = CORE_FETCH;
            CORE_FETCH:     if (fetch_done) w_next_state = CORE_DECODE;
            CORE_DECODE:    w_next_state = CORE_REQUEST;
            CORE_REQUEST:   w_next_state = CORE_WAIT;
            CORE_WAIT: begin
                if (w_lanes_idle) begin
                    w_next_state = CORE_EXECUTE;
                end else if (w_wait_expired) begin
                    w_next_state = CORE_DONE;
                end
            end
            CORE_EXECUTE:   w_next_state = CORE_WRITEBACK;
            CORE_WRITEBACK: w_next_state = decoded_ret ? CORE_DONE : CORE_FETCH;
            CORE_DONE:      w_next_state = CORE_DONE;
            default:        w_next_state = CORE_IDLE;
        endcase
    end

    // Datapath registers: the PC, the WAIT counter and the sticky completion
    // flags. They update in step with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= 8'd0;
            r_wait_cnt <= 8'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                CORE_IDLE: begin
                    if (start) r_pc <= 8'd0;
                end
                CORE_REQUEST: begin
                    r_wait_cnt <= 8'd0;
                end
                CORE_WAIT: begin
                    if (!w_lanes_idle) begin
                        if (w_wait_expired) begin
                            r_error <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                end
                CORE_WRITEBACK: begin
                    // The lanes supply the next PC. No wrap or increment is
                    // applied here.
                    if (decoded_ret) begin
                        r_done <= 1'b1;
                    end else begin
                        r_pc <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode. fetch_req is the only output not taken straight from a
    // register.
    always_comb begin
        core_state = r_state;
        fetch_req  = (r_state == CORE_FETCH);
        current_pc = r_pc;
        done       = r_done;
        error      = r_error;
    end

endmodule

// File: tb/tb_core_scheduler.sv
module tb_core_scheduler;

  localparam int THREADS = 4;
  localparam int TMO     = 8;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_REQUEST = 3'd3, ST_WAIT = 3'd4, ST_EXECUTE = 3'd5,
                         ST_WRITEBACK = 3'd6, ST_DONE = 3'd7;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] thread_count = 3'd4;
  logic       fetch_done = 1'b0;
  logic       decoded_ret = 1'b0;
  logic [3:0] lsu_busy = 4'h0;
  logic [7:0] next_pc = 8'h00;
  logic [2:0] core_state;
  logic       fetch_req;
  logic [7:0] current_pc;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  core_scheduler #(.THREADS(THREADS), .WAIT_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .fetch_done(fetch_done), .decoded_ret(decoded_ret), .lsu_busy(lsu_busy),
    .next_pc(next_pc), .core_state(core_state), .fetch_req(fetch_req),
    .current_pc(current_pc), .done(done), .error(error)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic       start;
    logic       fd;
    logic       ret;
    logic [3:0] busy;
    logic [7:0] npc;
    logic [2:0] tc;
    logic [2:0] e_state;
    logic [7:0] e_pc;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vec_q[$];
  vec_t plan1_tab[19];

  int total = 0;
  int bad   = 0;

  // model of the kernel being built
  logic [7:0] m_pc;
  logic [2:0] m_tc;
  logic       m_done;
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic [7:0] pc,
                               input logic dn, input logic er);
    chk({tag, ".state"}, 32'(core_state), 32'(st));
    chk({tag, ".pc"}, 32'(current_pc), 32'(pc));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".error"}, 32'(error), 32'(er));
    chk({tag, ".fetch_req"}, 32'(fetch_req), 32'(st == ST_FETCH));
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    start        = v.start;
    fetch_done   = v.fd;
    decoded_ret  = v.ret;
    lsu_busy     = v.busy;
    next_pc      = v.npc;
    thread_count = v.tc;
    step();
    check_outputs(tag, v.e_state, v.e_pc, v.e_done, v.e_err);
  endtask

  task automatic run_queue(input string tag);
    foreach (vec_q[i]) apply_vec(vec_q[i], tag);
    vec_q.delete();
  endtask

  // Asynchronous reset, with the outputs checked before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_outputs("reset_async", ST_IDLE, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_outputs("reset_idle", ST_IDLE, 8'h00, 1'b0, 1'b0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] lane_mask(input int tc);
    if (tc >= THREADS) return 4'hF;
    return 4'((1 << tc) - 1);
  endfunction

  // Inputs that the current state does not look at are randomised.
  function automatic vec_t rnd_vec();
    vec_t v;
    v.start   = 1'($urandom_range(0, 1));
    v.fd      = 1'($urandom_range(0, 1));
    v.ret     = 1'($urandom_range(0, 1));
    v.busy    = 4'($urandom_range(0, 15));
    v.npc     = 8'($urandom_range(0, 255));
    v.tc      = m_tc;
    v.e_state = ST_IDLE;
    v.e_pc    = 8'h00;
    v.e_done  = 1'b0;
    v.e_err   = 1'b0;
    return v;
  endfunction

  function automatic void push(input vec_t v, input logic [2:0] st);
    v.e_state = st;
    v.e_pc    = m_pc;
    v.e_done  = m_done;
    v.e_err   = m_err;
    vec_q.push_back(v);
  endfunction

  task automatic begin_kernel(input logic [2:0] tc, input int idle);
    vec_t v;
    do_reset();
    m_tc = tc; m_pc = 8'h00; m_done = 1'b0; m_err = 1'b0;
    for (int i = 0; i < idle; i++) begin
      v = rnd_vec(); v.start = 1'b0; push(v, ST_IDLE);
    end
    v = rnd_vec(); v.start = 1'b1; push(v, ST_FETCH);
  endtask

  // One instruction: d stall cycles in FETCH; for the first b WAIT cycles
  // lsu_busy = hi, after that lo.
  task automatic add_instr(input int d, input int b, input logic [3:0] hi, input logic [3:0] lo,
                           input logic ret, input logic [7:0] npc, output bit ended);
    vec_t v;
    ended = 1'b0;
    for (int j = 0; j < d; j++) begin
      v = rnd_vec(); v.fd = 1'b0; push(v, ST_FETCH);
    end
    v = rnd_vec(); v.fd = 1'b1; push(v, ST_DECODE);
    v = rnd_vec(); push(v, ST_REQUEST);
    v = rnd_vec(); push(v, ST_WAIT);
    for (int k = 0; ; k++) begin
      v = rnd_vec();
      v.busy = (k < b) ? hi : lo;
      if ((v.busy & lane_mask(int'(m_tc))) == 4'h0) begin
        push(v, ST_EXECUTE);
        break;
      end else if (k == TMO - 1) begin
        m_err = 1'b1;
        push(v, ST_DONE);
        ended = 1'b1;
        return;
      end else begin
        push(v, ST_WAIT);
      end
    end
    v = rnd_vec(); push(v, ST_WRITEBACK);
    v = rnd_vec(); v.ret = ret; v.npc = npc;
    if (ret) begin
      m_done = 1'b1;
      push(v, ST_DONE);
      ended = 1'b1;
    end else begin
      m_pc = npc;
      push(v, ST_FETCH);
    end
  endtask

  task automatic end_kernel(input int n, input string tag);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = rnd_vec(); push(v, ST_DONE);
    end
    run_queue(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ended;
    logic [3:0] lo;

    // Three back-to-back 6-cycle instructions, RET on the third.
    // Fields: start fd ret busy npc tc | state pc done err
    plan1_tab = '{
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 3'd4, 3'd1, 8'h00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 3'd4, 3'd2, 8'h00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 3'd4, 3'd3, 8'h00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 3'd4, 3'd4, 8'h00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 3'd4, 3'd5, 8'h00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 3'd4, 3'd6, 8'h00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 3'd4, 3'd1, 8'h01, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 3'd4, 3'd2, 8'h01, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 3'd4, 3'd3, 8'h01, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 3'd4, 3'd4, 8'h01, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 3'd4, 3'd5, 8'h01, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 3'd4, 3'd6, 8'h01, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 3'd4, 3'd1, 8'h02, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h03, 3'd4, 3'd2, 8'h02, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h03, 3'd4, 3'd3, 8'h02, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h03, 3'd4, 3'd4, 8'h02, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h03, 3'd4, 3'd5, 8'h02, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 8'h03, 3'd4, 3'd6, 8'h02, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 4'h0, 8'h03, 3'd4, 3'd7, 8'h02, 1'b1, 1'b0}
    };

    m_tc = 3'd4; m_pc = 8'h00; m_done = 1'b0; m_err = 1'b0;
    #1;
    check_outputs("por", ST_IDLE, 8'h00, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 19; i++) apply_vec(plan1_tab[i], "plan1");
    m_pc = 8'h02; m_done = 1'b1;
    end_kernel(3, "plan1_hold");

    // FETCH stalled for 5 cycles.
    begin_kernel(3'd4, 1);
    add_instr(5, 0, 4'h0, 4'h0, 1'b1, 8'h00, ended);
    end_kernel(2, "fetch_stall");

    // Lanes outside the mask are ignored; WAIT lasts 4 cycles.
    begin_kernel(3'd2, 0);
    add_instr(0, 3, 4'b1110, 4'b1100, 1'b1, 8'h00, ended);
    end_kernel(2, "mask");

    // Stuck lane leads to the WAIT timeout; start is ignored afterwards.
    begin_kernel(3'd1, 1);
    add_instr(0, 1000, 4'b0001, 4'b0000, 1'b0, 8'h00, ended);
    end_kernel(5, "timeout");

    // PC wrap is taken verbatim; an empty mask exits WAIT at once.
    begin_kernel(3'd0, 0);
    add_instr(0, 50, 4'hF, 4'hF, 1'b0, 8'hFF, ended);
    add_instr(1, 50, 4'hF, 4'hF, 1'b0, 8'h00, ended);
    add_instr(0, 50, 4'hF, 4'hF, 1'b1, 8'h55, ended);
    end_kernel(2, "pc_wrap");

    // Asynchronous reset in the middle of WAIT, then a fresh start.
    begin_kernel(3'd4, 0);
    add_instr(0, 0, 4'h0, 4'h0, 1'b0, 8'h12, ended);
    run_queue("mid_reset_pre");
    start = 1'b0; fetch_done = 1'b1; lsu_busy = 4'hF; thread_count = 3'd4;
    step(); step(); step(); step();
    check_outputs("mid_reset_wait", ST_WAIT, 8'h12, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_outputs("mid_reset_async", ST_IDLE, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    step();
    check_outputs("mid_reset_restart", ST_FETCH, 8'h00, 1'b0, 1'b0);

    // Random kernels checked against the model.
    for (int n = 0; n < 40; n++) begin
      begin_kernel(3'($urandom_range(0, 7)), $urandom_range(0, 2));
      ended = 1'b0;
      for (int i = 0; i < 6 && !ended; i++) begin
        lo = 4'($urandom_range(0, 15)) & ~lane_mask(int'(m_tc));
        add_instr($urandom_range(0, 3), $urandom_range(0, 10), 4'($urandom_range(0, 15)), lo,
                  (i == 5) || ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), ended);
      end
      end_kernel($urandom_range(1, 3), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core control FSM that sequences the shared `core_state` bus seen by every thread's register file, ALU, LSU and PC unit.
- Steps one instruction at a time: FETCH → DECODE → REQUEST → WAIT → EXECUTE → WRITEBACK.
- Holds the converged program counter and detects kernel completion (RET).
- Detects a stalled memory wait and aborts with an error flag.

Parameters:
- THREADS, 4: number of thread lanes in the core (width of `lsu_busy`).
- WAIT_TIMEOUT, 255: maximum cycles spent in WAIT before abort. Range 1..255.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  level; launches the kernel when sampled high in IDLE.
- thread_count  input  3  number of active lanes for this block; 0..THREADS.
- fetch_done  input  1  fetcher has the instruction for `current_pc` latched.
- decoded_ret  input  1  decoded instruction is RET; valid from DECODE onward.
- lsu_busy  input  THREADS  bit i high while lane i's LSU is requesting or waiting.
- next_pc  input  8  PC computed by the lanes, valid in WRITEBACK.
- core_state  output  3  current state, encoded per `CORE_*` in defines.vh.
- fetch_req  output  1  high exactly while `core_state` == FETCH.
- current_pc  output  8  address of the instruction in flight.
- done  output  1  kernel finished normally.
- error  output  1  WAIT timeout abort.

Behaviour:

Encodings: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, WRITEBACK=6, DONE=7.

Reset values: `core_state`=IDLE, `current_pc`=0, `done`=0, `error`=0, internal wait counter=0. Reset asserted mid-instruction returns to IDLE on the same edge and discards the instruction.

Active-lane mask:
- Bit i is set iff i < `thread_count`.
- `thread_count` > THREADS saturates to all ones.
- `thread_count`=0 gives an empty mask, so WAIT exits immediately.
- Lanes outside the mask are ignored even if their `lsu_busy` bit is high.

State transitions (all registered, one per clock):
- IDLE: `start`=1 → FETCH, `current_pc`<=0. Otherwise stay.
- FETCH: `fetch_req`=1. `fetch_done`=1 → DECODE; otherwise stay, with no timeout.
- DECODE: unconditional → REQUEST (1 cycle).
- REQUEST: unconditional → WAIT (1 cycle). Wait counter <= 0. This is the cycle in which register files sample rs/rt.
- WAIT:
  - If (`lsu_busy` & mask)==0 → EXECUTE.
  - Else, if counter == WAIT_TIMEOUT-1 → DONE with `error`<=1, `done` stays 0.
  - Else counter <= counter+1.
  - The exit check has priority over the timeout in the same cycle.
  - Minimum WAIT residency is 1 cycle.
- EXECUTE: unconditional → WRITEBACK (1 cycle).
- WRITEBACK (register files commit in this cycle):
  - `decoded_ret`=1 → DONE, `done`<=1, `current_pc` unchanged.
  - Else `current_pc`<=`next_pc` → FETCH.
- DONE: terminal; `done`/`error` held. Only reset leaves DONE. `start` is ignored.

Other rules:
- `start` is ignored in every state except IDLE.
- `next_pc` is taken verbatim (8-bit); 255→0 wrap is the lanes' responsibility, and there is no internal increment.
- Minimum instruction latency: 6 cycles, i.e. FETCH with `fetch_done` already high, and WAIT exiting on its first cycle.
- `done` and `error` are mutually exclusive.
- All outputs are registered except `fetch_req`, which is decoded from the state register.

Test Plan:
1. Reset then `start`=1, `fetch_done`=1, `lsu_busy`=0, `thread_count`=4, `next_pc`=`current_pc`+1, RET on the 3rd instruction → `core_state` sequence 0,1,2,3,4,5,6 repeated ×3; `current_pc` 0→1→2; final state 7 with `done`=1, `error`=0, 19 cycles after start.
2. Hold `fetch_done`=0 for 5 cycles in FETCH → state stays 1 with `fetch_req`=1 for 6 cycles; DECODE follows the cycle after `fetch_done` rises.
3. `thread_count`=2, `lsu_busy`=4'b1100 held, then 4'b0010 for 3 WAIT cycles → masked lanes ignored; WAIT lasts 4 cycles, then EXECUTE.
4. WAIT_TIMEOUT=8, `lsu_busy`=4'b0001 stuck → exactly 8 cycles in WAIT, then state 7, `error`=1, `done`=0; later `start` toggles leave the state at 7.
5. Assert `reset` asynchronously mid-WAIT (between edges) with `current_pc`=0x12 → outputs go to 0 immediately, before the next edge; a fresh `start` restarts from pc 0.
6. `next_pc`=0xFF then 0x00 across two instructions, and `thread_count`=0 with `lsu_busy`=4'hF → `current_pc` follows 0xFF→0x00 exactly; WAIT exits after 1 cycle.
